// File: rtl/ip_sound_mixer.sv
// Three-channel sample mixer: per-channel volume, mute and master gain on one shared multiplier.
// Gains are written by the CPU through an index/data I/O port pair.
module ip_sound_mixer #(
  parameter logic [7:0] IO_BASE = 8'h4C
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic               mclk_pcen_n,
  input  logic               n_ioreq,
  input  logic               n_wr,
  input  logic [15:0]        address,
  input  logic [7:0]         wdata,
  input  logic [10:0]        scc_in,
  input  logic [15:0]        opll_in,
  input  logic [7:0]         ssg_in,
  output logic signed [16:0] sound_out,
  output logic               sound_valid
);

  localparam logic [7:0] DATA_PORT = IO_BASE + 8'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAP,
    S_SCC,
    S_OPLL,
    S_SSG,
    S_MST
  } state_t;

  state_t r_state;

  logic [2:0] r_sync;
  logic       w_strobe_n;
  logic       w_wr_stb;
  logic [7:0] w_addr;

  logic [7:0] r_vol_scc;
  logic [7:0] r_vol_opll;
  logic [7:0] r_vol_ssg;
  logic [7:0] r_vol_mst;
  logic [2:0] r_mute;
  logic [2:0] r_index;

  logic signed [16:0] r_c_scc;
  logic signed [16:0] r_c_opll;
  logic signed [16:0] r_c_ssg;
  logic [7:0]         r_c_vscc;
  logic [7:0]         r_c_vopll;
  logic [7:0]         r_c_vssg;
  logic [7:0]         r_c_vmst;
  logic [2:0]         r_c_mute;

  logic signed [19:0] r_acc;

  logic signed [16:0] w_scc_al;
  logic signed [16:0] w_opll_al;
  logic signed [16:0] w_ssg_al;
  logic signed [19:0] w_mul_a;
  logic [7:0]         w_mul_b;
  logic               w_mul_mute;
  logic signed [28:0] w_prod;
  logic signed [21:0] w_scaled;
  logic signed [19:0] w_term;
  logic signed [16:0] w_sat;
  logic               w_unused;

  assign w_strobe_n = n_ioreq | n_wr;
  assign w_wr_stb   = ~r_sync[1] & r_sync[2];
  assign w_addr     = address[7:0];

  // r_sync[1:0] synchronise the strobe, r_sync[2] delays it for the falling-edge detect
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_sync <= 3'b111;
    end else begin
      r_sync <= {r_sync[1:0], w_strobe_n};
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_index    <= 3'd0;
      r_vol_scc  <= 8'h80;
      r_vol_opll <= 8'h80;
      r_vol_ssg  <= 8'h80;
      r_vol_mst  <= 8'h80;
      r_mute     <= 3'b000;
    end else if (w_wr_stb) begin
      unique case (1'b1)
        (w_addr == IO_BASE): begin
          r_index <= wdata[2:0];
        end
        (w_addr == DATA_PORT): begin
          case (r_index)
            3'd0:    r_vol_scc  <= wdata;
            3'd1:    r_vol_opll <= wdata;
            3'd2:    r_vol_ssg  <= wdata;
            3'd3:    r_vol_mst  <= wdata;
            3'd4:    r_mute     <= wdata[2:0];
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign w_scc_al  = {scc_in[10], scc_in, 5'b00000};
  assign w_opll_al = {opll_in[15], opll_in};
  assign w_ssg_al  = {{4{ssg_in[7]}}, ssg_in, 5'b00000};

  always_comb begin
    w_mul_a    = '0;
    w_mul_b    = '0;
    w_mul_mute = 1'b0;
    case (r_state)
      S_SCC: begin
        w_mul_a    = 20'(r_c_scc);
        w_mul_b    = r_c_vscc;
        w_mul_mute = r_c_mute[0];
      end
      S_OPLL: begin
        w_mul_a    = 20'(r_c_opll);
        w_mul_b    = r_c_vopll;
        w_mul_mute = r_c_mute[1];
      end
      S_SSG: begin
        w_mul_a    = 20'(r_c_ssg);
        w_mul_b    = r_c_vssg;
        w_mul_mute = r_c_mute[2];
      end
      S_MST: begin
        w_mul_a = r_acc;
        w_mul_b = r_c_vmst;
      end
      default: ;
    endcase
  end

  // Dropping the low 7 product bits of a signed value is a floor divide by 128
  assign w_prod   = w_mul_a * $signed({1'b0, w_mul_b});
  assign w_scaled = w_prod[28:7];
  assign w_term   = w_mul_mute ? 20'sd0 : w_scaled[19:0];

  always_comb begin
    w_sat = w_scaled[16:0];
    if (w_scaled > 22'sd65535) begin
      w_sat = 17'sh0FFFF;
    end else if (w_scaled < -22'sd65536) begin
      w_sat = 17'sh10000;
    end
  end

  assign w_unused = ^{w_prod[6:0], address[15:8]};

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_c_scc     <= '0;
      r_c_opll    <= '0;
      r_c_ssg     <= '0;
      r_c_vscc    <= '0;
      r_c_vopll   <= '0;
      r_c_vssg    <= '0;
      r_c_vmst    <= '0;
      r_c_mute    <= '0;
      sound_out   <= '0;
      sound_valid <= 1'b0;
    end else begin
      sound_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!mclk_pcen_n) begin
            r_state <= S_CAP;
          end
        end
        S_CAP: begin
          r_c_scc   <= w_scc_al;
          r_c_opll  <= w_opll_al;
          r_c_ssg   <= w_ssg_al;
          r_c_vscc  <= r_vol_scc;
          r_c_vopll <= r_vol_opll;
          r_c_vssg  <= r_vol_ssg;
          r_c_vmst  <= r_vol_mst;
          r_c_mute  <= r_mute;
          r_state   <= S_SCC;
        end
        S_SCC: begin
          r_acc   <= w_term;
          r_state <= S_OPLL;
        end
        S_OPLL: begin
          r_acc   <= r_acc + w_term;
          r_state <= S_SSG;
        end
        S_SSG: begin
          r_acc   <= r_acc + w_term;
          r_state <= S_MST;
        end
        S_MST: begin
          sound_out   <= w_sat;
          sound_valid <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
